// File: rtl/hbridge_drv.sv
// H-bridge output stage: dead-time insertion, conflict rejection, driver reset stretching
// and latched fault shutdown per channel. Optional conflict_flag port: HBRIDGE_DRV_CONFLICT_EN.
module hbridge_drv #(
    parameter int unsigned N_CHANNELS   = 6,
    parameter int unsigned DEAD_CYCLES  = 24,
    parameter int unsigned RESET_CYCLES = 240
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [N_CHANNELS-1:0] cmd_left,
    input  logic [N_CHANNELS-1:0] cmd_right,
    input  logic [N_CHANNELS-1:0] cmd_reset,
    input  logic [N_CHANNELS-1:0] fault_in,
    input  logic [N_CHANNELS-1:0] fault_clear,
    output logic [N_CHANNELS-1:0] pwm_a,
    output logic [N_CHANNELS-1:0] pwm_b,
    output logic [N_CHANNELS-1:0] drv_reset_n,
    output logic [N_CHANNELS-1:0] fault_latched
`ifdef HBRIDGE_DRV_CONFLICT_EN
    ,
    output logic [N_CHANNELS-1:0] conflict_flag
`endif
);

    localparam int unsigned DW = $clog2(DEAD_CYCLES + 1);
    localparam int unsigned RW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {ST_OFF, ST_LEFT, ST_RIGHT, ST_DEAD} state_e;

    state_e          state_q    [N_CHANNELS];
    state_e          state_d    [N_CHANNELS];
    logic [DW-1:0]   dead_cnt_q [N_CHANNELS];
    logic [DW-1:0]   dead_cnt_d [N_CHANNELS];
    logic [RW-1:0]   rst_cnt_q  [N_CHANNELS];
    logic [RW-1:0]   rst_cnt_d  [N_CHANNELS];

    logic [N_CHANNELS-1:0] fault_meta_q, fault_meta_d;
    logic [N_CHANNELS-1:0] fault_sync_q, fault_sync_d;
    logic [N_CHANNELS-1:0] fault_latched_q, fault_latched_d;
    logic [N_CHANNELS-1:0] pwm_a_q, pwm_a_d;
    logic [N_CHANNELS-1:0] pwm_b_q, pwm_b_d;
    logic [N_CHANNELS-1:0] drv_reset_n_q, drv_reset_n_d;
    logic [N_CHANNELS-1:0] cmd_l, cmd_r, blocked;

    always_comb begin
        fault_meta_d    = fault_in;
        fault_sync_d    = fault_meta_q;
        // set has priority; clear only takes effect once the fault source is gone
        fault_latched_d = fault_sync_q | (fault_latched_q & ~(fault_clear & ~fault_sync_q));
        cmd_l           = cmd_left & ~cmd_right;
        cmd_r           = cmd_right & ~cmd_left;
        blocked         = {N_CHANNELS{~enable}} | fault_latched_q | ~drv_reset_n_q;
        pwm_a_d         = '0;
        pwm_b_d         = '0;
        drv_reset_n_d   = '0;

        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            if (cmd_reset[i]) begin
                rst_cnt_d[i] = RW'(RESET_CYCLES);
            end else if (rst_cnt_q[i] != '0) begin
                rst_cnt_d[i] = rst_cnt_q[i] - RW'(1);
            end else begin
                rst_cnt_d[i] = rst_cnt_q[i];
            end
            drv_reset_n_d[i] = (rst_cnt_d[i] == '0);

            state_d[i]    = state_q[i];
            dead_cnt_d[i] = dead_cnt_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (!blocked[i] && cmd_l[i]) begin
                        state_d[i] = ST_LEFT;
                    end else if (!blocked[i] && cmd_r[i]) begin
                        state_d[i] = ST_RIGHT;
                    end
                end
                ST_LEFT: begin
                    if (!cmd_l[i] || blocked[i]) begin
                        state_d[i]    = ST_DEAD;
                        dead_cnt_d[i] = DW'(DEAD_CYCLES);
                    end
                end
                ST_RIGHT: begin
                    if (!cmd_r[i] || blocked[i]) begin
                        state_d[i]    = ST_DEAD;
                        dead_cnt_d[i] = DW'(DEAD_CYCLES);
                    end
                end
                ST_DEAD: begin
                    // leave as the counter reaches zero so OFF can re-drive on the following edge
                    dead_cnt_d[i] = dead_cnt_q[i] - DW'(1);
                    if (dead_cnt_q[i] <= DW'(1)) begin
                        state_d[i]    = ST_OFF;
                        dead_cnt_d[i] = '0;
                    end
                end
                default: begin
                    state_d[i]    = ST_OFF;
                    dead_cnt_d[i] = '0;
                end
            endcase

            pwm_a_d[i] = (state_d[i] == ST_LEFT);
            pwm_b_d[i] = (state_d[i] == ST_RIGHT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_meta_q    <= '0;
            fault_sync_q    <= '0;
            fault_latched_q <= '0;
            pwm_a_q         <= '0;
            pwm_b_q         <= '0;
            drv_reset_n_q   <= '0;
            for (int unsigned i = 0; i < N_CHANNELS; i++) begin
                state_q[i]    <= ST_OFF;
                dead_cnt_q[i] <= '0;
                rst_cnt_q[i]  <= RW'(RESET_CYCLES);
            end
        end else begin
            fault_meta_q    <= fault_meta_d;
            fault_sync_q    <= fault_sync_d;
            fault_latched_q <= fault_latched_d;
            pwm_a_q         <= pwm_a_d;
            pwm_b_q         <= pwm_b_d;
            drv_reset_n_q   <= drv_reset_n_d;
            for (int unsigned i = 0; i < N_CHANNELS; i++) begin
                state_q[i]    <= state_d[i];
                dead_cnt_q[i] <= dead_cnt_d[i];
                rst_cnt_q[i]  <= rst_cnt_d[i];
            end
        end
    end

    assign pwm_a         = pwm_a_q;
    assign pwm_b         = pwm_b_q;
    assign drv_reset_n   = drv_reset_n_q;
    assign fault_latched = fault_latched_q;

`ifdef HBRIDGE_DRV_CONFLICT_EN
    logic [N_CHANNELS-1:0] conflict_q, conflict_d;

    always_comb begin
        conflict_d = (conflict_q & ~fault_clear) | (cmd_left & cmd_right & ~blocked);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_flag = conflict_q;
`else
    // conflicting commands already resolve to "no command" through cmd_l / cmd_r
`endif

endmodule

// File: tb/tb_hbridge_drv.sv
// Directed self-checking bench for hbridge_drv (default parameters, 6 channels).
module tb_hbridge_drv;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [5:0] cmd_left = '0;
    logic [5:0] cmd_right = '0;
    logic [5:0] cmd_reset = '0;
    logic [5:0] fault_in = '0;
    logic [5:0] fault_clear = '0;
    logic [5:0] pwm_a, pwm_b, drv_reset_n, fault_latched;
`ifdef HBRIDGE_DRV_CONFLICT_EN
    logic [5:0] conflict_flag;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cnt, cnt2, n;

    hbridge_drv #(
        .N_CHANNELS  (6),
        .DEAD_CYCLES (24),
        .RESET_CYCLES(240)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cmd_left     (cmd_left),
        .cmd_right    (cmd_right),
        .cmd_reset    (cmd_reset),
        .fault_in     (fault_in),
        .fault_clear  (fault_clear),
        .pwm_a        (pwm_a),
        .pwm_b        (pwm_b),
        .drv_reset_n  (drv_reset_n),
        .fault_latched(fault_latched)
`ifdef HBRIDGE_DRV_CONFLICT_EN
        ,
        .conflict_flag(conflict_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        tick(3);
        chk("rst_pwm_a", pwm_a, 6'h00);
        chk("rst_pwm_b", pwm_b, 6'h00);
        chk("rst_drv_n", drv_reset_n, 6'h00);
        chk("rst_fault", fault_latched, 6'h00);

        // 1: reset stretch after release
        reset = 1'b0;
        cnt = 0; cnt2 = 0;
        for (int k = 1; k <= 240; k++) begin
            tick(1);
            if (drv_reset_n == 6'h00) cnt++;
            if ((pwm_a | pwm_b) != 6'h00) cnt2++;
            if (k == 239) chk("t1_still_low", drv_reset_n, 6'h00);
        end
        chk("t1_low_cycles", cnt, 239);
        chk("t1_release", drv_reset_n, 6'h3F);
        chk("t1_pwm_quiet", cnt2, 0);

        // 2: left drive, drop, early re-request held off by dead time
        cmd_left[0] = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            tick(1);
            if (pwm_a[0]) cnt++;
            if (k == 1) chk("t2_rise", pwm_a, 6'h01);
        end
        chk("t2_high_cycles", cnt, 100);
        cmd_left[0] = 1'b0;
        tick(1);
        chk("t2_drop", pwm_a, 6'h00);
        tick(8);
        cmd_left[0] = 1'b1;
        cnt = 0;
        for (int k = 110; k <= 125; k++) begin
            tick(1);
            if (pwm_a[0]) cnt++;
        end
        chk("t2_dead_hold", cnt, 0);
        tick(1);
        chk("t2_redrive", pwm_a, 6'h01);
        cmd_left[0] = 1'b0;
        tick(30);
        chk("t2_idle", pwm_a | pwm_b, 6'h00);

        // 3: direct reversal goes through dead time
        cmd_left[2] = 1'b1;
        tick(2);
        chk("t3_left", pwm_a, 6'h04);
        cmd_left[2] = 1'b0;
        cmd_right[2] = 1'b1;
        tick(1);
        chk("t3_drop", pwm_a | pwm_b, 6'h00);
        cnt = 0; cnt2 = 0;
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            if (pwm_b[2]) cnt++;
            if (pwm_a[2] & pwm_b[2]) cnt2++;
        end
        chk("t3_dead_hold", cnt, 0);
        tick(1);
        chk("t3_reverse_b", pwm_b, 6'h04);
        chk("t3_reverse_a", pwm_a, 6'h00);
        chk("t3_overlap", cnt2, 0);
        cmd_right[2] = 1'b0;
        tick(30);

        // 4: conflicting commands
        cmd_left[1] = 1'b1;
        cmd_right[1] = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            if (pwm_a[1] | pwm_b[1]) cnt++;
        end
        chk("t4_both_off", cnt, 0);
`ifdef HBRIDGE_DRV_CONFLICT_EN
        chk("t4_conflict_set", conflict_flag, 6'h02);
`endif
        cmd_left[1] = 1'b0;
        cmd_right[1] = 1'b0;
        tick(3);
`ifdef HBRIDGE_DRV_CONFLICT_EN
        chk("t4_conflict_sticky", conflict_flag, 6'h02);
        fault_clear[1] = 1'b1;
        tick(1);
        fault_clear[1] = 1'b0;
        chk("t4_conflict_clr", conflict_flag, 6'h00);
`endif
        chk("t4_idle", pwm_a | pwm_b, 6'h00);

        // 5: fault shutdown while driving right
        cmd_right[3] = 1'b1;
        tick(2);
        chk("t5_right", pwm_b, 6'h08);
        fault_in[3] = 1'b1;
        n = 0;
        while (fault_latched[3] !== 1'b1 && n < 8) begin
            tick(1);
            n++;
        end
        chk("t5_latch_delay", n, 3);
        tick(1);
        chk("t5_pwm_off", pwm_b, 6'h00);
        fault_clear[3] = 1'b1;
        tick(1);
        fault_clear[3] = 1'b0;
        chk("t5_clear_while_high", fault_latched, 6'h08);
        tick(30);
        chk("t5_blocked", pwm_b, 6'h00);
        fault_in[3] = 1'b0;
        tick(4);
        chk("t5_sticky", fault_latched, 6'h08);
        fault_clear[3] = 1'b1;
        tick(1);
        fault_clear[3] = 1'b0;
        chk("t5_cleared", fault_latched, 6'h00);
        tick(1);
        chk("t5_resume", pwm_b, 6'h08);
        cmd_right[3] = 1'b0;
        tick(30);

        // 6: global enable drop, then driver reset pulse
        cmd_left = 6'h3F;
        tick(2);
        chk("t6_all_left", pwm_a, 6'h3F);
        enable = 1'b0;
        tick(1);
        chk("t6_off", pwm_a | pwm_b, 6'h00);
        tick(9);
        enable = 1'b1;
        cnt = 0;
        for (int k = 11; k <= 25; k++) begin
            tick(1);
            if (pwm_a != 6'h00) cnt++;
        end
        chk("t6_dead_hold", cnt, 0);
        tick(1);
        chk("t6_restart", pwm_a, 6'h3F);

        cmd_reset = 6'h3F;
        tick(1);
        cmd_reset = 6'h00;
        chk("t6_rst_low", drv_reset_n, 6'h00);
        cnt = 0;
        for (int k = 2; k <= 240; k++) begin
            tick(1);
            if (drv_reset_n == 6'h00) cnt++;
            if (k == 2) chk("t6_rst_pwm_off", pwm_a, 6'h00);
        end
        chk("t6_rst_low_cycles", cnt, 239);
        tick(1);
        chk("t6_rst_release", drv_reset_n, 6'h3F);
        tick(1);
        chk("t6_resume", pwm_a, 6'h3F);

        // reset mid-operation
        reset = 1'b1;
        tick(1);
        chk("midrst_pwm", pwm_a | pwm_b, 6'h00);
        chk("midrst_drv", drv_reset_n, 6'h00);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hbridge_drv.md
Name: hbridge_drv

Overview:
- Output stage directly downstream of the DC motor controller core.
- Consumes its per-channel motor_left / motor_right PWM commands and motor_reset requests, and drives the H-bridge driver pins (PWM_A/PWM_B pairs, active-low RESET).
- Adds break-before-make dead time, direction-conflict rejection, reset pulse stretching and a latched fault shutdown. No command can ever drive both bridge inputs of a channel at once.

Parameters:
- N_CHANNELS, 6, number of motor channels.
- DEAD_CYCLES, 24, dead-time length in clk cycles (1 us at 24 MHz); must be >= 1.
- RESET_CYCLES, 240, minimum low time of a driver reset in clk cycles (10 us at 24 MHz); must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global output enable; low forces all channels off.
- cmd_left  in  N_CHANNELS  left-direction PWM command, from motor_left.
- cmd_right  in  N_CHANNELS  right-direction PWM command, from motor_right.
- cmd_reset  in  N_CHANNELS  driver reset request, level or pulse, from motor_reset.
- fault_in  in  N_CHANNELS  asynchronous active-high driver fault.
- fault_clear  in  N_CHANNELS  per-channel fault latch clear.
- pwm_a  out  N_CHANNELS  bridge input A.
- pwm_b  out  N_CHANNELS  bridge input B.
- drv_reset_n  out  N_CHANNELS  active-low driver reset.
- fault_latched  out  N_CHANNELS  sticky fault status.

Behaviour:
- All outputs are registered.
- Reset values: pwm_a=0, pwm_b=0, drv_reset_n=0, fault_latched=0. Every FSM goes to OFF; every reset counter is loaded with RESET_CYCLES.
- After reset deasserts, drv_reset_n stays 0 for RESET_CYCLES more cycles.
- fault_in passes through a 2-FF synchronizer before use.
- Per-channel FSM states: OFF, LEFT, RIGHT, DEAD. Dead counter width is clog2(DEAD_CYCLES+1).
- Channel "blocked" := !enable || fault_latched || drv_reset_n==0 (registered value).
- Effective commands: L = cmd_left & ~cmd_right; R = cmd_right & ~cmd_left. When both are high, both are treated as 0.
- OFF:
  - Outputs are 0/0.
  - If not blocked and L, go to LEFT; if not blocked and R, go to RIGHT.
  - pwm_a / pwm_b rise exactly 1 cycle after the command is sampled.
- LEFT:
  - pwm_a=1, pwm_b=0.
  - If !L or blocked: both outputs go low the next cycle, dead counter loads DEAD_CYCLES, go to DEAD.
- RIGHT: mirror of LEFT, with pwm_b=1.
- DEAD:
  - Outputs 0/0; counter decrements each cycle.
  - At 0, go to OFF. The OFF state then evaluates commands, so re-drive is earliest DEAD_CYCLES+1 cycles after the drop.
  - A direct LEFT<->RIGHT reversal always passes through DEAD.
- Reset stretcher:
  - While cmd_reset is high, the counter reloads RESET_CYCLES and drv_reset_n=0.
  - Otherwise the counter decrements; drv_reset_n=1 when it reaches 0.
  - Retriggerable.
  - Width is clog2(RESET_CYCLES+1).
- Fault latch:
  - Set when synchronized fault_in=1.
  - Cleared by fault_clear only when synchronized fault_in=0.
  - Simultaneous set and clear: set wins.
- Entering blocked from LEFT/RIGHT always goes via DEAD, never directly to OFF.
- reset mid-operation: outputs are 0 on the next edge, and all state is reinitialised.
- Channels are fully independent; no shared counters.

Optional Feature:
- Macro HBRIDGE_DRV_CONFLICT_EN.
- Defined: adds output port conflict_flag [N_CHANNELS]. It is set sticky on any cycle where cmd_left & cmd_right are both high on a non-blocked channel. It is cleared by fault_clear of that channel or by reset.
- Undefined: port and logic are absent; conflict input is silently treated as no command.

Test Plan:
1. Release reset with all commands 0 -> drv_reset_n low for exactly RESET_CYCLES=240 cycles after reset falls, then 1; pwm_a=pwm_b=0 throughout.
2. cmd_left[0]=1 for 100 cycles, then 0 -> pwm_a[0] high cycles 1..100, low from cycle 101. cmd_left reasserted at cycle 110 -> pwm_a rises at cycle 101+DEAD_CYCLES+1=126, not earlier.
3. cmd_left[2] 1 -> 0 with cmd_right[2]=1 on the same cycle -> pwm_a low next cycle, pwm_b high exactly 25 cycles later; never both high.
4. cmd_left=cmd_right=1 on channel 1 -> both outputs stay 0. With HBRIDGE_DRV_CONFLICT_EN: conflict_flag[1]=1 until fault_clear[1].
5. fault_in[3] pulses high while RIGHT -> 2-3 cycles later fault_latched[3]=1, pwm_b low, DEAD entered. fault_clear with fault_in high -> stays latched. Clear after fault_in low -> commands honoured again.
6. enable low for 10 cycles during LEFT on all channels -> all outputs 0 within 1 cycle. After enable returns, outputs restart only after DEAD expiry; 1-cycle cmd_reset -> drv_reset_n low 240 cycles.
